// File: rtl/regfile_mp.sv
// Multi-port integer register file: NUM_RD combinational read ports,
// two bypassed write ports, post-reset hardware clear and collision flag.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       init_done_o,
    output logic                       wcollide_o,
    input  logic                       we0_i,
    input  logic [ADDR_W-1:0]          waddr0_i,
    input  logic [DATA_W-1:0]          wdata0_i,
    input  logic                       we1_i,
    input  logic [ADDR_W-1:0]          waddr1_i,
    input  logic [DATA_W-1:0]          wdata1_i,
    input  logic [NUM_RD-1:0]          re_i,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr_i,
    output logic [NUM_RD*DATA_W-1:0]   rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [DATA_W-1:0]   regs [DEPTH];
    logic                wr0;
    logic                wr1;
    logic                run;

    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return (a != '0) || (ZERO_REG == 0);
    endfunction

    assign run = (state == RUN) && !rst;
    assign wr0 = run && we0_i && writable(waddr0_i);
    assign wr1 = run && we1_i && writable(waddr1_i);

    assign init_done_o = run;

    always_comb begin
        state_nx = state;
        if (state == CLEAR && clr_cnt == ADDR_W'(DEPTH - 1)) begin
            state_nx = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // Port 1 is younger: its assignment comes last so it wins on a shared address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[clr_cnt] <= '0;
            end else begin
                if (wr0) begin
                    regs[waddr0_i] <= wdata0_i;
                end
                if (wr1) begin
                    regs[waddr1_i] <= wdata1_i;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcollide_o <= 1'b0;
        end else if (wr0 && wr1 && waddr0_i == waddr1_i) begin
            wcollide_o <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = raddr_i[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd = '0;
            if (rst || state != RUN) begin
                rd = '0;
            end else if (!re_i[k]) begin
                rd = '0;
            end else if (ra == '0 && ZERO_REG != 0) begin
                rd = '0;
            end else if (we1_i && waddr1_i == ra) begin
                rd = wdata1_i;
            end else if (we0_i && waddr0_i == ra) begin
                rd = wdata0_i;
            end else begin
                rd = regs[ra];
            end
        end

        assign rdata_o[k*DATA_W +: DATA_W] = rd;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: one instance with a hard-wired r0
// and one with an ordinary r0, sharing all inputs.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic        we0, we1;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata, rdata_nz;
    logic        done, done_nz;
    logic        coll, coll_nz;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    regfile_mp #(.ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .init_done_o(done), .wcollide_o(coll),
        .we0_i(we0), .waddr0_i(waddr0), .wdata0_i(wdata0),
        .we1_i(we1), .waddr1_i(waddr1), .wdata1_i(wdata1),
        .re_i(re), .raddr_i(raddr), .rdata_o(rdata)
    );

    regfile_mp #(.ZERO_REG(0)) dut_nz (
        .clk(clk), .rst(rst),
        .init_done_o(done_nz), .wcollide_o(coll_nz),
        .we0_i(we0), .waddr0_i(waddr0), .wdata0_i(wdata0),
        .we1_i(we1), .waddr1_i(waddr1), .wdata1_i(wdata1),
        .re_i(re), .raddr_i(raddr), .rdata_o(rdata_nz)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_addr(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
        #1;
    endtask

    function automatic logic [31:0] p0(input logic [63:0] d);
        return d[31:0];
    endfunction

    function automatic logic [31:0] p1(input logic [63:0] d);
        return d[63:32];
    endfunction

    initial begin
        rst = 1'b1;
        we0 = 1'b0; we1 = 1'b0;
        waddr0 = '0; waddr1 = '0;
        wdata0 = '0; wdata1 = '0;
        re = 2'b11;
        raddr = '0;

        // Reset held three cycles
        repeat (3) tick();
        check("rst_done", 32'(done), 32'd0);
        check("rst_coll", 32'(coll), 32'd0);
        check("rst_rd0", p0(rdata), 32'd0);
        check("rst_rd1", p1(rdata), 32'd0);

        // Clear takes exactly 32 edges after release
        rst = 1'b0;
        #1;
        check("clr_rd_early", p0(rdata), 32'd0);
        for (int i = 1; i <= 32; i++) begin
            tick();
            check($sformatf("clr_done_%0d", i), 32'(done),
                  (i == 32) ? 32'd1 : 32'd0);
        end
        check("clr_done_nz", 32'(done_nz), 32'd1);

        for (int a = 0; a < 32; a++) begin
            rd_addr(5'(a), 5'(31 - a));
            check($sformatf("clr_p0_r%0d", a), p0(rdata), 32'd0);
            check($sformatf("clr_p1_r%0d", 31 - a), p1(rdata), 32'd0);
            check($sformatf("clr_nz_r%0d", a), p0(rdata_nz), 32'd0);
        end

        // Dual write, distinct addresses
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h1111_2222;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'hAAAA_5555;
        tick();
        we0 = 1'b0; we1 = 1'b0;
        rd_addr(5'd3, 5'd7);
        check("dual_r3", p0(rdata), 32'h1111_2222);
        check("dual_r7", p1(rdata), 32'hAAAA_5555);
        check("dual_coll", 32'(coll), 32'd0);
        check("dual_coll_nz", 32'(coll_nz), 32'd0);

        // Both ports to r0
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF_FFFF;
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'hFFFF_FFFF;
        rd_addr(5'd0, 5'd0);
        check("z_byp", p0(rdata), 32'd0);
        check("z_byp_nz", p0(rdata_nz), 32'hFFFF_FFFF);
        tick();
        we0 = 1'b0; we1 = 1'b0;
        #1;
        check("z_arr", p1(rdata), 32'd0);
        check("z_arr_nz", p1(rdata_nz), 32'hFFFF_FFFF);
        check("z_coll", 32'(coll), 32'd0);
        check("z_coll_nz", 32'(coll_nz), 32'd1);

        // Collision on r9: port 1 wins
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h1;
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h2;
        rd_addr(5'd9, 5'd9);
        check("col_byp0", p0(rdata), 32'h2);
        check("col_byp1", p1(rdata), 32'h2);
        check("col_pre", 32'(coll), 32'd0);
        tick();
        we0 = 1'b0; we1 = 1'b0;
        #1;
        check("col_arr", p0(rdata), 32'h2);
        check("col_flag", 32'(coll), 32'd1);
        tick();
        check("col_sticky", 32'(coll), 32'd1);

        // Read enable and port-0 bypass
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h5;
        tick();
        we0 = 1'b0;
        re = 2'b01;
        rd_addr(5'd5, 5'd5);
        check("re_p0", p0(rdata), 32'h5);
        check("re_p1_off", p1(rdata), 32'h0);
        re = 2'b11;
        we0 = 1'b1; wdata0 = 32'h6;
        #1;
        check("byp_p0", p0(rdata), 32'h6);
        check("byp_p1", p1(rdata), 32'h6);
        tick();
        we0 = 1'b0;
        #1;
        check("byp_arr", p1(rdata), 32'h6);
        check("byp_old_r3", p0(rdata), 32'h6);
        rd_addr(5'd3, 5'd7);
        check("keep_r3", p0(rdata), 32'h1111_2222);

        // Reset clears the sticky flag, then reset again at clear edge 10
        rst = 1'b1;
        tick();
        check("rr_coll", 32'(coll), 32'd0);
        check("rr_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (9) tick();
        check("mid_done", 32'(done), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hDEAD_BEEF;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'hCAFE_F00D;
        rd_addr(5'd3, 5'd7);
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 32) begin
                we0 = 1'b0; we1 = 1'b0;
                #1;
            end else begin
                check($sformatf("rc_rd_%0d", i), p0(rdata), 32'd0);
            end
            check($sformatf("rc_done_%0d", i), 32'(done),
                  (i == 32) ? 32'd1 : 32'd0);
        end
        check("rc_r3", p0(rdata), 32'd0);
        check("rc_r7", p1(rdata), 32'd0);
        check("rc_r7_nz", p1(rdata_nz), 32'd0);
        rd_addr(5'd9, 5'd5);
        check("rc_r9", p0(rdata), 32'd0);
        check("rc_r5", p1(rdata), 32'd0);
        check("rc_coll", 32'(coll), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the integer pipeline; successor to the two-read/one-write register file. Provides NUM_RD combinational read ports and two write ports (port 1 younger than port 0), each with write-to-read bypass. A hardware clear sequencer zeroes every register after reset. A sticky flag records same-address dual-write collisions. Sits between ID (read ports) and WB (write ports).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 hard-wired to zero
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active high
- init_done_o  out  1  1 = clear sequence finished, file usable
- wcollide_o  out  1  sticky: both write ports hit the same writable address in one cycle
- we0_i  in  1  write enable, port 0 (older)
- waddr0_i  in  ADDR_W  write address, port 0
- wdata0_i  in  DATA_W  write data, port 0
- we1_i  in  1  write enable, port 1 (younger)
- waddr1_i  in  ADDR_W  write address, port 1
- wdata1_i  in  DATA_W  write data, port 1
- re_i  in  NUM_RD  per-port read enable
- raddr_i  in  NUM_RD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
- rdata_o  out  NUM_RD*DATA_W  packed read data; port k = bits [k*DATA_W +: DATA_W]

## Operation
- Two-state FSM: CLEAR, RUN.
- CLEAR entry: any clock edge with rst=1 sets state=CLEAR and clr_cnt=0. While rst=1, the counter does not advance and no writes occur.
- CLEAR: on each edge with rst=0, regs[clr_cnt] <= 0 and clr_cnt++. When clr_cnt == DEPTH-1, the same edge writes that last register and moves the FSM to RUN.
- During CLEAR, both write ports are ignored and init_done_o=0.
- RUN: init_done_o=1. The FSM stays in RUN until rst is asserted again.
- Write (RUN only): port p writes when wep_i=1 and the target is writable. An address is writable unless it is 0 and ZERO_REG=1.
  - If both ports write the same address, port 1 data is stored.
  - Distinct addresses are written independently in the same cycle.
- wcollide_o: registered. It is set on an edge in RUN when we0_i and we1_i are both 1, waddr0_i == waddr1_i, and the address is writable. It stays set until reset and is cleared by rst.
- Read port k is combinational. rdata_o[k] is evaluated in this priority order:
  1. rst=1 or state=CLEAR → 0
  2. re_i[k]=0 → 0
  3. raddr_k=0 and ZERO_REG=1 → 0
  4. we1_i=1 and waddr1_i==raddr_k → wdata1_i
  5. we0_i=1 and waddr0_i==raddr_k → wdata0_i
  6. otherwise → regs[raddr_k]
- Read ports are fully independent; any number may read the same address.
- With ZERO_REG=0, register 0 is an ordinary register and is both writable and bypassable.

## Timing
- Reset values: init_done_o=0, wcollide_o=0, all rdata_o=0 while rst=1.
- Clear latency: after the first edge with rst=0, exactly DEPTH edges elapse before RUN. For DEPTH=32, init_done_o rises after the 32nd edge.
- Reset asserted mid-CLEAR or mid-RUN: on the next edge, state=CLEAR and clr_cnt=0, and the full clear restarts.
- Write: data is stored on the edge where we is sampled high. Before that edge it is visible same-cycle through bypass; after it, it is visible from the array.
- Read latency: 0 cycles (combinational); no read handshake.
- Writes presented while init_done_o=0 are dropped, not deferred.

## Test plan
- Reset/clear (DEPTH=32): hold rst high 3 cycles, then release.
  - init_done_o=0 for exactly 32 edges, then 1.
  - All 32 registers read 0x00000000.
- Dual write, distinct addresses: we0 r3=0x11112222 and we1 r7=0xAAAA5555 in one cycle.
  - Next cycle, port0 reads r3=0x11112222 and port1 reads r7=0xAAAA5555.
  - wcollide_o stays 0.
- Collision: both ports write r9 (port0=0x1, port1=0x2) in one cycle.
  - Same-cycle bypass read returns 0x2; next-cycle array read returns 0x2.
  - wcollide_o=1 from the following cycle until rst.
- Zero register: write r0=0xFFFFFFFF on both ports.
  - r0 reads 0 in the same and next cycle; wcollide_o stays 0.
  - Repeat with ZERO_REG=0: r0 reads 0xFFFFFFFF and wcollide_o=1.
- Read enable and bypass: with r5=0x5, set re_i=0 on port1 → rdata1=0.
  - With we0 r5=0x6 same cycle and re_i=1 → both ports read 0x6.
- Reset mid-clear: assert rst at clear edge 10, release.
  - Clear restarts; init_done_o rises 32 edges after release.
  - Writes issued during the clear are dropped (registers read 0).
